// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, stalling on the memready handshake.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       memreq,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQ     = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        BNE     = 4'd12
    } state_t;

    state_t     cur_state;
    state_t     next_state;
    logic [1:0] aluop;

    always_ff @(posedge clk) begin
        if (reset) cur_state <= FETCH;
        else       cur_state <= next_state;
    end

    assign state = cur_state;

    always_comb begin
        next_state = FETCH;
        memreq     = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        illegal    = 1'b0;
        case (cur_state)
            FETCH: begin
                memreq     = 1'b1;
                alusrcb    = 2'b01;
                irwrite    = memready;
                pcen       = memready;
                next_state = memready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    6'b100011, 6'b101011: next_state = MEMADR;
                    6'b000000:            next_state = EXECUTE;
                    6'b000100:            next_state = BEQ;
                    6'b000101:            next_state = BNE;
                    6'b001000:            next_state = ADDIEX;
                    6'b000010:            next_state = JUMP;
                    default: begin
                        illegal    = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = (op == 6'b100011) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memreq     = 1'b1;
                iord       = 1'b1;
                next_state = memready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                memreq     = 1'b1;
                iord       = 1'b1;
                memwrite   = 1'b1;
                next_state = memready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                alusrca    = 1'b1;
                aluop      = 2'b10;
                next_state = ALUWB;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQ: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                pcen    = zero;
            end
            BNE: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                pcen    = ~zero;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: next_state = FETCH;
        endcase

        // Reset overrides the decode: no enables, mux selects parked at FETCH values.
        if (reset) begin
            memreq   = 1'b0;
            iord     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            regwrite = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = 2'b01;
            aluop    = 2'b00;
            pcsrc    = 2'b00;
            pcen     = 1'b0;
            illegal  = 1'b0;
        end
    end

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instruction table, multi-cycle corner
// sequences, and randomized instruction streams against a path-based model.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       memreq, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic       alusrca, pcen, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .memready(memready), .memreq(memreq), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] ref_alu(input logic [5:0] f);
        case (f)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         lat;
        int         rw;
        int         mw;
        int         pe;
        int         il;
    } vec_t;

    vec_t vecs[10];

    // Run one instruction with memready=1 until the FSM is back in FETCH.
    task automatic run_tab(input vec_t v, output int cyc, output int rw,
                           output int mw, output int pe, output int il);
        cyc = 0; rw = 0; mw = 0; pe = 0; il = 0;
        op = v.op; funct = v.funct; zero = v.zero; memready = 1'b1;
        do begin
            @(negedge clk);
            rw += int'(regwrite);
            mw += int'(memwrite);
            pe += int'(pcen);
            il += int'(illegal);
            cyc++;
            step();
        end while (state != 4'd0 && cyc < 20);
    endtask

    initial begin
        int cyc, rw, mw, pe, il;
        int lw_mr[7], lw_st[7], sw_mr[7], sw_st[7];
        int budget;

        vecs[0] = '{"radd",   6'h00, 6'h20, 1'b0, 4, 1, 0, 1, 0};
        vecs[1] = '{"lw",     6'h23, 6'h00, 1'b0, 5, 1, 0, 1, 0};
        vecs[2] = '{"sw",     6'h2b, 6'h00, 1'b0, 4, 0, 1, 1, 0};
        vecs[3] = '{"beq_z1", 6'h04, 6'h00, 1'b1, 3, 0, 0, 2, 0};
        vecs[4] = '{"beq_z0", 6'h04, 6'h00, 1'b0, 3, 0, 0, 1, 0};
        vecs[5] = '{"bne_z1", 6'h05, 6'h00, 1'b1, 3, 0, 0, 1, 0};
        vecs[6] = '{"bne_z0", 6'h05, 6'h00, 1'b0, 3, 0, 0, 2, 0};
        vecs[7] = '{"addi",   6'h08, 6'h00, 1'b0, 4, 1, 0, 1, 0};
        vecs[8] = '{"j",      6'h02, 6'h00, 1'b0, 3, 0, 0, 2, 0};
        vecs[9] = '{"ill",    6'h3f, 6'h00, 1'b0, 2, 0, 0, 1, 1};

        reset = 1'b1; op = '0; funct = '0; zero = 1'b0; memready = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_enables", {memreq, memwrite, irwrite, regwrite, pcen, illegal}, 0);
        chk("rst_alusrcb", alusrcb, 2'b01);
        chk("rst_alucontrol", alucontrol, 3'b010);
        @(posedge clk);
        #1 reset = 1'b0;

        // Table-driven single instructions
        foreach (vecs[i]) begin
            run_tab(vecs[i], cyc, rw, mw, pe, il);
            chk({vecs[i].name, "_lat"}, cyc, vecs[i].lat);
            chk({vecs[i].name, "_regwrite"}, rw, vecs[i].rw);
            chk({vecs[i].name, "_memwrite"}, mw, vecs[i].mw);
            chk({vecs[i].name, "_pcen"}, pe, vecs[i].pe);
            chk({vecs[i].name, "_illegal"}, il, vecs[i].il);
        end

        // lw with two stall cycles in MEMRD
        lw_mr = '{1, 1, 1, 0, 0, 1, 1};
        lw_st = '{0, 1, 2, 3, 3, 3, 4};
        op = 6'h23;
        for (int i = 0; i < 7; i++) begin
            memready = lw_mr[i][0];
            @(negedge clk);
            chk("lw_stall_state", state, lw_st[i]);
            if (lw_st[i] == 3) chk("lw_iord", iord, 1);
            chk("lw_wb", {memtoreg, regwrite}, (lw_st[i] == 4) ? 2'b11 : 2'b00);
            step();
        end
        chk("lw_stall_end", state, 0);

        // sw with three stall cycles in MEMWR
        sw_mr = '{1, 1, 1, 0, 0, 0, 1};
        sw_st = '{0, 1, 2, 5, 5, 5, 5};
        op = 6'h2b; mw = 0; rw = 0;
        for (int i = 0; i < 7; i++) begin
            memready = sw_mr[i][0];
            @(negedge clk);
            chk("sw_stall_state", state, sw_st[i]);
            mw += int'(memwrite);
            rw += int'(regwrite);
            step();
        end
        chk("sw_memwrite_cycles", mw, 4);
        chk("sw_no_regwrite", rw, 0);
        chk("sw_stall_end", state, 0);

        // Reset aborts a stalled store
        op = 6'h2b; memready = 1'b1;
        step(); step(); step();
        memready = 1'b0;
        @(negedge clk);
        chk("abort_pre_memwrite", memwrite, 1);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("abort_memwrite", {memwrite, memreq}, 0);
        step();
        chk("abort_state", state, 0);
        reset = 1'b0; memready = 1'b1;
        @(negedge clk);
        chk("abort_refetch", {irwrite, pcen}, 2'b11);
        step();
        chk("abort_decode", state, 1);
        budget = 0;
        while (state != 4'd0 && budget < 20) begin
            step();
            budget++;
        end
        chk("abort_drain", state, 0);

        // Randomized instruction stream against a path model
        for (int n = 0; n < 300; n++) begin
            int path[$];
            int idx, st, waits, k;
            logic [5:0] fl[6];
            logic [6:0] exp_ctl;
            logic mr, z;
            fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};
            k = $urandom_range(0, 7);
            funct = fl[$urandom_range(0, 5)];
            case (k)
                0: begin op = 6'h00; path = '{0, 1, 6, 7}; end
                1: begin op = 6'h23; path = '{0, 1, 2, 3, 4}; end
                2: begin op = 6'h2b; path = '{0, 1, 2, 5}; end
                3: begin op = 6'h04; path = '{0, 1, 8}; end
                4: begin op = 6'h05; path = '{0, 1, 12}; end
                5: begin op = 6'h08; path = '{0, 1, 9, 10}; end
                6: begin op = 6'h02; path = '{0, 1, 11}; end
                default: begin
                    op = ($urandom_range(0, 1) == 0) ? 6'h3f : 6'h01;
                    path = '{0, 1};
                end
            endcase
            idx = 0; waits = 0;
            while (idx < path.size()) begin
                st = path[idx];
                mr = (waits >= 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
                z = 1'($urandom_range(0, 1));
                memready = mr; zero = z;
                @(negedge clk);
                chk("rnd_state", state, st);
                exp_ctl[6] = (st == 0 || st == 3 || st == 5);
                exp_ctl[5] = (st == 3 || st == 5);
                exp_ctl[4] = (st == 5);
                exp_ctl[3] = (st == 0) && mr;
                exp_ctl[2] = (st == 4 || st == 7 || st == 10);
                exp_ctl[1] = ((st == 0) && mr) || (st == 11) ||
                             ((st == 8) && z) || ((st == 12) && !z);
                exp_ctl[0] = (st == 1) && (k == 7);
                chk("rnd_ctrl", {memreq, iord, memwrite, irwrite, regwrite, pcen, illegal},
                    exp_ctl);
                if (st == 6) chk("rnd_rtype_alu", alucontrol, ref_alu(funct));
                if (st == 8 || st == 12) chk("rnd_branch_alu", {alucontrol, pcsrc}, 5'b110_01);
                if (st == 2 || st == 9) chk("rnd_addr_alu", {alucontrol, alusrcb}, 5'b010_10);
                step();
                if ((st == 0 || st == 3 || st == 5) && !mr) begin
                    waits++;
                end else begin
                    idx++;
                    waits = 0;
                end
            end
        end
        chk("rnd_end_state", state, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
